mpe_stream_feeder: RTL
======================

Name: mpe_stream_feeder

Overview:
- Transmitter end of the valid/ready operand stream consumed by matrix_pe (nram_mpe_neuron / wram_mpe_weight ports).
- Once configured, it reads a contiguous run of 512-bit lines from a synchronous on-chip SRAM (NRAM or WRAM) and presents them in order on a valid/ready stream.
- It holds data stable under back-pressure and sustains one beat per cycle when the sink is always ready.
- One instance per operand stream.

Parameters:
- DATA_W, 512, stream/SRAM line width in bits
- ADDR_W, 16, SRAM line-address width; also the width of the length field
- FIFO_DEPTH, 2, output buffer entries; minimum 2, must be a power of two

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle start request; sampled only in IDLE
- cfg_base  in  ADDR_W  first line address, captured on accepted start
- cfg_len  in  ADDR_W  number of lines, captured on accepted start; 0 is legal
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the final beat handshakes (or when a zero-length job completes)
- ram_rd_en  out  1  SRAM read enable
- ram_rd_addr  out  ADDR_W  SRAM read address
- ram_rd_data  in  DATA_W  SRAM read data, valid exactly 1 cycle after ram_rd_en
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from the PE

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - busy=0, done=0, ram_rd_en=0, ram_rd_addr=0, out_valid=0, out_data=0.
  - FIFO empty, all counters 0, state IDLE.
  - Reset asserted mid-job aborts the job immediately. Read data returning after reset deasserts is dropped. No done pulse is issued.
- States:
  - IDLE: cfg_start=1 and cfg_len!=0 -> RUN; capture base/len; busy=1 next cycle. cfg_start=1 and cfg_len==0 -> DONE.
  - RUN: issues reads. When the issued count equals len -> DRAIN.
  - DRAIN: waits until the handshake count equals len -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - cfg_start outside IDLE is ignored.
- Zero length: start at cycle t gives done=1 at t+1 with busy=0 throughout. No ram_rd_en, no out_valid.
- Read issue:
  - ram_rd_en=1 in a cycle iff state is RUN, issued<len, and (fifo_count + inflight - pop) < FIFO_DEPTH.
  - inflight is 0 or 1 (the read issued last cycle). pop = out_valid & out_ready.
  - ram_rd_addr = base + issued, truncated to ADDR_W (wraps 0xFFFF -> 0x0000).
- Return path: the cycle after ram_rd_en, ram_rd_data is written into the FIFO tail. Credit gating guarantees the FIFO never overflows; a write into a full FIFO is a design error (bench assertion).
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head, driven from registers.
  - While out_valid=1 and out_ready=0, out_data and out_valid stay stable.
  - out_valid never deasserts without a handshake.
- Simultaneous FIFO write and pop: both take effect and the count is unchanged. A FIFO that is both empty and being written presents the new head on the next cycle.
- Latency: start accepted at t -> first ram_rd_en at t+1 -> first out_valid at t+3.
- Throughput: with out_ready held at 1, len beats complete in len consecutive cycles after the first.
- done is asserted the cycle after the last handshake.
- Counters issued and accepted are ADDR_W+1 bits wide, so len=0xFFFF completes without overflow.

Decomposition:
- Shared package mpe_pkg: DATA_W/ADDR_W defaults, the feeder state enum (IDLE, RUN, DRAIN, DONE), and the SRAM read-latency constant (1).
- One natural sub-module: mpe_sync_fifo (parameterised DATA_W/DEPTH, push/pop/count, registered head output). It is reusable on the result path.

Test Plan:
- Reset and idle: rst_n low for 10 cycles, then cfg_start with len=0 -> done pulse 1 cycle after start, no ram_rd_en, no out_valid, busy stays 0.
- Full rate: base=0x0000, len=4, out_ready=1 constantly, SRAM line n = n+1 -> out_data sequence 1,2,3,4 on 4 consecutive cycles; first out_valid 3 cycles after start; done 1 cycle after the 4th beat.
- Back-pressure: len=140, out_ready = the same per-cycle $random%2 pattern as the PE bench -> exactly 140 handshakes, in-order data, out_data stable while stalled, no FIFO overflow assertion fires.
- Address wrap: base=0xFFFE, len=4 -> reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001 with data matching in order.
- Start while busy: second cfg_start (base=0x100, len=2) mid-job -> ignored; only the first job's beats appear; a single done pulse.
- Mid-job reset: assert rst_n low after 2 of 8 beats -> all outputs 0 immediately. A new job with len=3 after release delivers exactly 3 correct beats.

Source files
------------

// File: rtl/mpe_pkg.sv
// Shared constants for the matrix_pe operand feeders: default widths,
// feeder FSM encoding and on-chip SRAM read latency.
package mpe_pkg;

   localparam int unsigned MPE_DATA_W  = 512;
   localparam int unsigned MPE_ADDR_W  = 16;
   localparam int unsigned SRAM_RD_LAT = 1;

   localparam int unsigned FEED_ST_W = 2;

   localparam logic [FEED_ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [FEED_ST_W-1:0] ST_RUN   = 2'd1;
   localparam logic [FEED_ST_W-1:0] ST_DRAIN = 2'd2;
   localparam logic [FEED_ST_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mpe_sync_fifo.sv
// Small synchronous FIFO with register-array storage; the head entry is
// presented directly from flops so downstream sees a registered output.
module mpe_sync_fifo #(
   parameter int unsigned DATA_W = 512,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push_i,
   input  logic [DATA_W-1:0]               push_data_i,
   input  logic                            pop_i,
   output logic [DATA_W-1:0]               head_o,
   output logic [$clog2(DEPTH):0]          count_o,
   output logic                            empty_o,
   output logic                            full_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              push_ok;
   logic              pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   // A push into a full FIFO is only honoured when it is freed in the same cycle.
   assign push_ok = push_i && (!full_o || pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
         wr_ptr_q <= wr_ptr_q + PTR_W'(push_ok);
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop_ok);
         count_q  <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/mpe_stream_feeder.sv
// Streams a contiguous run of SRAM lines onto a valid/ready operand port,
// credit-gating reads so the output buffer can never overflow.
module mpe_stream_feeder
   import mpe_pkg::*;
#(
   parameter int unsigned DATA_W     = MPE_DATA_W,
   parameter int unsigned ADDR_W     = MPE_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_len,
   output logic              busy,
   output logic              done,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OCC_W  = FCNT_W + 1;

   logic [FEED_ST_W-1:0] state_q, state_d;
   logic [ADDR_W-1:0]    base_q, base_d;
   logic [CNT_W-1:0]     len_q, len_d;
   logic [CNT_W-1:0]     issued_q, issued_d;
   logic [CNT_W-1:0]     accepted_q, accepted_d;
   logic                 inflight_q;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 pop;
   logic                 rd_en_c;
   logic [OCC_W-1:0]     occ;
   logic [FCNT_W-1:0]    fifo_count;
   logic                 fifo_empty;
   logic                 fifo_full;

   assign pop = out_valid && out_ready;

   // Occupancy the buffer will reach once the outstanding read lands.
   assign occ = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);

   assign rd_en_c = (state_q == ST_RUN) && (issued_q < len_q) &&
                    (occ < OCC_W'(FIFO_DEPTH));

   assign ram_rd_en   = rd_en_c;
   assign ram_rd_addr = base_q + issued_q[ADDR_W-1:0];

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      issued_d   = issued_q + CNT_W'(rd_en_c);
      accepted_d = accepted_q + CNT_W'(pop);

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               base_d     = cfg_base;
               len_d      = CNT_W'(cfg_len);
               issued_d   = '0;
               accepted_d = '0;
               state_d    = (cfg_len != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (issued_q == len_q) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (accepted_d == len_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         accepted_q <= '0;
         inflight_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         accepted_q <= accepted_d;
         inflight_q <= rd_en_c;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   // Read data is captured the cycle after the enable; a reset clears inflight so stale returns drop.
   mpe_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i (ram_rd_data),
      .pop_i       (pop),
      .head_o      (out_data),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   assign out_valid = !fifo_empty;

endmodule
